// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the two ALU requesters, the consumer, the shared ALU and alu_share_arbiter.
// Handshakes: a transfer happens at a rising edge where valid && ready are both high; the
// source holds its payload stable while valid && !ready, and ready never depends on anything
// but the arbiter state and the valids.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] alu_data_1;
    logic [WIDTH-1:0] alu_data_2;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_flag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_flag;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, alu_flag, rsp_ready,
        output req0_ready, req1_ready, alu_data_1, alu_data_2, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_flag, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, alu_flag, rsp_ready,
        input  req0_ready, req1_ready, alu_data_1, alu_data_2, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_flag, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: IDLE grants, EXEC drives the ALU,
// RESP holds the captured result. Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic             rsp_id_q, rsp_flag_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             grant0, grant1;
    logic             ready0, ready1;
    logic [WIDTH-1:0] alu_d1, alu_d2;
    logic [2:0]       alu_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant0 = bus.req0_valid;
    assign grant1 = bus.req1_valid & ~bus.req0_valid;
`else
    // last_q = 1 means requester 1 won last, so requester 0 wins the next tie.
    logic last_q;
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && (grant0 || grant1)) begin
            last_q <= grant1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        ready0  = 1'b0;
        ready1  = 1'b0;
        alu_d1  = '0;
        alu_d2  = '0;
        alu_op  = 3'b000;
        case (state_q)
            IDLE: begin
                ready0 = grant0;
                ready1 = grant1;
                if (grant0 || grant1) state_d = EXEC;
            end
            EXEC: begin
                alu_d1  = a_q;
                alu_d2  = b_q;
                alu_op  = op_q;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_flag_q   <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (grant0 || grant1)) begin
                op_q <= grant1 ? bus.req1_op : bus.req0_op;
                a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
                b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
                id_q <= grant1;
            end
            // The ALU flag is only meaningful for sub; reserved opcode yields all zeros.
            if (state_q == EXEC) begin
                rsp_id_q     <= id_q;
                rsp_flag_q   <= (op_q == 3'b001) & bus.alu_flag;
                rsp_result_q <= (op_q == 3'b111) ? '0 : bus.alu_result;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_data_1 = alu_d1;
    assign bus.alu_data_2 = alu_d2;
    assign bus.alu_ctrl   = alu_op;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_flag   = rsp_flag_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.busy       = (state_q != IDLE);
    assign state_o        = state_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] state_dbg;
  logic force_dead = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [W+1:0] exp_q[$];  // {id, flag, result}

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W)) bus();

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_o(state_dbg)
  );

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = {{(W-1){1'b0}}, a < b};
      3'd6: r = {{(W-1){1'b0}}, b != '0};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W+1:0] exp_of(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic f;
    r = (op == 3'b111) ? {W{1'b0}} : ref_alu(op, a, b);
    f = (op == 3'b001) && (a == b);
    return {id, f, r};
  endfunction

  // Behavioural ALU; its equality flag is live for every opcode so masking is exercised.
  always_comb begin
    bus.alu_result = force_dead ? 32'hDEADBEEF : ref_alu(bus.alu_ctrl, bus.alu_data_1, bus.alu_data_2);
    bus.alu_flag   = (bus.alu_data_1 == bus.alu_data_2);
  end

  // Response monitor: a handshake seen at a negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      logic [W+1:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected got id=%0d flag=%0d result=%h required no response",
                 bus.rsp_id, bus.rsp_flag, bus.rsp_result);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rsp_id, bus.rsp_flag, bus.rsp_result} !== e) begin
          n_fail++;
          $display("FAIL rsp got id=%0d flag=%0d result=%h required id=%0d flag=%0d result=%h",
                   bus.rsp_id, bus.rsp_flag, bus.rsp_result, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1 set_req(id, op, a, b);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        exp_q.push_back(exp_of(id, op, a, b));
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL issue_timeout got no ready for requester %0d required a grant", id);
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) return;
    end
    n_tests++; n_fail++;
    $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_id, bus.rsp_flag} !== 6'b0 ||
        bus.rsp_result !== '0 || bus.alu_data_1 !== '0 || bus.alu_data_2 !== '0 ||
        bus.alu_ctrl !== 3'b000 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%0d rsp_valid=%0d result=%h ctrl=%0d required all zero",
               bus.busy, bus.rsp_valid, bus.rsp_result, bus.alu_ctrl);
    end
  endtask

  task automatic test_add();
    issue(1'b0, 3'b000, 32'd5, 32'd7);
    @(negedge clk);
    n_tests++;
    if (bus.alu_data_1 !== 32'd5 || bus.alu_data_2 !== 32'd7 || bus.alu_ctrl !== 3'b000 ||
        bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_exec got d1=%0d d2=%0d ctrl=%0d busy=%0d rsp_valid=%0d required 5 7 0 1 0",
               bus.alu_data_1, bus.alu_data_2, bus.alu_ctrl, bus.busy, bus.rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.alu_data_1 !== '0 || bus.alu_data_2 !== '0) begin
      n_fail++;
      $display("FAIL add_resp_timing got rsp_valid=%0d d1=%0d d2=%0d required 1 0 0",
               bus.rsp_valid, bus.alu_data_1, bus.alu_data_2);
    end
    drain();
  endtask

  task automatic test_sub();
    issue(1'b1, 3'b001, 32'h1234, 32'h1234);
    issue(1'b1, 3'b001, 32'd9, 32'd4);
    issue(1'b0, 3'b001, 32'd0, 32'd1);
    drain();
  endtask

  task automatic test_ops();
    for (int i = 0; i < 14; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom_range(0, 15);
      b = (i % 3 == 0) ? a : W'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), 3'(i % 7), a, b);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int got_n;
    int cyc;
    logic gid;
    logic exp_id;
    do_reset();
    @(posedge clk);
    #1;
    set_req(1'b0, 3'(($urandom_range(0, 6))), W'($urandom), W'($urandom));
    set_req(1'b1, 3'(($urandom_range(0, 6))), W'($urandom), W'($urandom));
    got_n = 0;
    cyc = 0;
    while (got_n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.req0_ready && bus.req1_ready) begin
        n_tests++; n_fail++;
        $display("FAIL b2b_double_grant got both ready required one");
      end else if (bus.req0_ready || bus.req1_ready) begin
        gid = bus.req1_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_id = 1'b0;
`else
        exp_id = got_n[0];
`endif
        n_tests++;
        if (gid !== exp_id) begin
          n_fail++;
          $display("FAIL b2b_grant%0d got %0d required %0d", got_n, gid, exp_id);
        end
        if (gid) exp_q.push_back(exp_of(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
        else     exp_q.push_back(exp_of(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
        got_n++;
        @(posedge clk);
        #1 set_req(gid, 3'(($urandom_range(0, 6))), W'($urandom), W'($urandom));
      end
    end
    if (got_n < 4) begin
      n_tests++; n_fail++;
      $display("FAIL b2b_timeout got %0d grants required 4", got_n);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_stall();
    logic [W+1:0] e;
    logic exp_id;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 32'h0F0F_1234, 32'h00FF_4321);
    e = exp_q[0];
    @(negedge clk);
    @(posedge clk);
    #1;
    set_req(1'b0, 3'b000, 32'd1, 32'd2);
    set_req(1'b1, 3'b010, 32'h10, 32'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          {bus.rsp_id, bus.rsp_flag, bus.rsp_result} !== e) begin
        n_fail++;
        $display("FAIL stall_hold%0d got valid=%0d r0=%0d r1=%0d result=%h required 1 0 0 %h",
                 i, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_result, e[W-1:0]);
      end
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = 1'b0;
`else
    exp_id = 1'b1;
`endif
    n_tests++;
    if (bus.req0_ready !== !exp_id || bus.req1_ready !== exp_id) begin
      n_fail++;
      $display("FAIL stall_regrant got r0=%0d r1=%0d required r%0d only",
               bus.req0_ready, bus.req1_ready, exp_id);
    end
    if (exp_id) exp_q.push_back(exp_of(1'b1, 3'b010, 32'h10, 32'h01));
    else        exp_q.push_back(exp_of(1'b0, 3'b000, 32'd1, 32'd2));
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_reserved();
    force_dead = 1'b1;
    issue(1'b1, 3'b111, 32'd77, 32'd77);
    @(negedge clk);
    n_tests++;
    if (bus.alu_ctrl !== 3'b111 || bus.alu_data_1 !== 32'd77) begin
      n_fail++;
      $display("FAIL reserved_exec got ctrl=%0d d1=%0d required 7 77", bus.alu_ctrl, bus.alu_data_1);
    end
    drain();
    force_dead = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    issue(1'b0, 3'b000, 32'd100, 32'd23);  // leaves a non-zero response and last grant = 0
    drain();
    @(posedge clk);
    #1 set_req(1'b0, 3'b010, 32'hAAAA, 32'h5555);
    for (t = 0; t < 20 && !bus.req0_ready; t++) @(negedge clk);
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.alu_data_1 !== 32'hAAAA) begin
      n_fail++;
      $display("FAIL rstmid_exec got busy=%0d d1=%h required 1 0000aaaa", bus.busy, bus.alu_data_1);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== '0 || bus.rsp_id !== 1'b0 ||
        bus.rsp_flag !== 1'b0 || bus.alu_data_1 !== '0 || bus.alu_data_2 !== '0 || bus.alu_ctrl !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_outputs got busy=%0d rsp_valid=%0d result=%h d1=%h required all zero",
               bus.busy, bus.rsp_valid, bus.rsp_result, bus.alu_data_1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_rsp got rsp_valid=%0d busy=%0d required 0 0", bus.rsp_valid, bus.busy);
    end
    @(posedge clk);
    #1;
    set_req(1'b0, 3'b100, 32'hF0F0, 32'hFF00);
    set_req(1'b1, 3'b011, 32'h1, 32'h3);
    @(negedge clk);
    n_tests++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_regrant got r0=%0d r1=%0d required 1 0", bus.req0_ready, bus.req1_ready);
    end
    exp_q.push_back(exp_of(1'b0, 3'b100, 32'hF0F0, 32'hFF00));
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ops();
    test_back_to_back();
    test_stall();
    test_reserved();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion required finish");
    $fatal(1, "watchdog");
  end
endmodule
